led_pwm_ctrl: RTL and testbench
===============================

# led_pwm_ctrl

Memory-mapped PWM controller for the board's status LED and RGB LED. It sits directly downstream of the multicycle core's datapath store path. It decodes word stores to a four-register window, double-buffers one 8-bit duty value per channel, and drives active-high `led`, `red`, `green`, `blue` levels. The top level inverts these levels for the active-low pads.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hFFFF_FFF0: base of the 16-byte register window; bits [3:0] must be zero.
- `PRESCALE`, default 188: clock cycles per PWM count step; legal range ≥1.

Ports:
- `clk` input 1: single clock; every register updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `mem_write` input 1: store strobe from the datapath, valid for one cycle.
- `addr` input 32: byte address of the store or load.
- `write_data` input 32: store data.
- `byte_en` input 4: byte lanes of the store (bit i enables bits [8i+7:8i]).
- `read_data` output 32: registered readback of the shadow duty.
- `led`, `red`, `green`, `blue` output 1 each: active-high PWM levels.

## Operation
- Hit: `addr[31:4] == BASE_ADDR[31:4]`. `addr[3:2]` selects the channel: 0 = led, 1 = red, 2 = green, 3 = blue. `addr[1:0]` is ignored.
- Write: `mem_write && hit && byte_en[0]` sets `shadow[ch] <= write_data[7:0]`.
  - Bits [31:8] are discarded.
  - A write with `byte_en[0]=0` changes nothing.
  - A write with no hit changes nothing.
- Read: every cycle, `read_data <= hit ? {24'b0, shadow[ch]} : 32'b0`.
  - The value is the shadow state before any write in the same cycle.
  - There is no read strobe.
- Prescaler: `pre` counts 0..PRESCALE-1. `tick` is asserted when `pre == PRESCALE-1`, and `pre` wraps to 0 on the same edge.
  - When PRESCALE=1, `tick` is asserted every cycle.
- PWM counter: 8-bit `cnt` increments on `tick` and wraps from 255 to 0.
- Period boundary: a `tick` with `cnt == 255` sets `active[ch] <= shadow[ch]` for all four channels together.
  - If a write coincides with the boundary, the write lands in shadow only. `active` takes the pre-write shadow, and the new value applies one period later.
- Output: `out[ch] <= (cnt < active[ch])`, unsigned 8-bit compare.
  - Duty 0 keeps the output permanently low.
  - Duty 255 gives 255/256 high. 100% is not reachable.
  - Duty N is high for the first N count steps of each period.
- Channels are independent. Writes never reset `pre` or `cnt`.

## Timing
- Reset (synchronous): `pre`, `cnt`, all `shadow`, all `active`, `read_data` and all four outputs go to 0.
  - Outputs stay low until the first boundary after a nonzero write.
  - Reset asserted mid-period discards the pending shadow and active values.
- The first boundary after reset occurs at cycle 256·PRESCALE − 1, counted from the first cycle with reset low.
- PWM period is 256·PRESCALE cycles. Each count step lasts PRESCALE cycles.
- Write to effect: the new duty reaches `active` at the next boundary strictly after the write cycle. The output reflects it one cycle later because of the registered compare.
- Output transitions lag the `cnt` change by exactly 1 cycle.
- Readback latency is 1 cycle from the `addr` being presented.
- A back-to-back write to the same channel in consecutive cycles leaves the last value in shadow. Only shadow contents present at a boundary ever reach `active`.

## Test plan
- **Reset:** hold `reset` for 3 cycles, release.
  - All outputs and `read_data` are 0.
  - Outputs stay 0 for 2 full periods with no writes.
- **Single write:** PRESCALE=2. Store 0x40 to BASE+0x4 with `byte_en=4'hF`.
  - `red` is 0 until the first boundary + 1 cycle.
  - Afterwards `red` is high for exactly 128 cycles of each 512-cycle period.
  - `led`, `green` and `blue` remain 0.
- **Extremes:** store 0x00 to `led` and 0xFF to `blue`.
  - `led` is never high.
  - `blue` is low for exactly PRESCALE cycles per period, aligned to `cnt == 255` plus 1 cycle.
- **Boundary collision:** store 0x80 to `green` on the exact boundary cycle, with prior shadow 0x10.
  - The next period shows 0x10 duty (32 cycles high at PRESCALE=2).
  - The following period shows 0x80 duty (256 cycles high).
- **Decode and lanes:**
  - A store to BASE+0x10 changes nothing.
  - A store to BASE+0x8 with `byte_en=4'b0010` changes nothing.
  - A store of 32'hDEAD_BE33 to BASE+0xC sets blue to 0x33, and reading BASE+0xC returns 32'h0000_0033 one cycle later.
  - Reading a non-hit address returns 0.
- **Reset mid-period:** set all duties to 0x80, run half a period, then pulse `reset`.
  - All outputs go to 0 on the next edge.
  - Readback of every channel is 0.
  - `cnt` restarts from 0.

Source files
------------

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped four-channel LED PWM controller: word-store decode into a
// double-buffered duty window, shared prescaler/period counter, registered outputs.
module led_pwm_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFF0,
  parameter int unsigned PRESCALE  = 188
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_en,
  output logic [31:0] read_data,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LOAD = PW'(PRESCALE - 1);

  // Prescaler runs as a down-counter; terminal count zero marks the count step.
  logic [PW-1:0] pre_left;
  logic [7:0]    cnt;
  logic [7:0]    shadow [4];
  logic [7:0]    active [4];
  logic [3:0]    pwm_q;
  logic          hit;
  logic          tick;
  logic          boundary;
  logic          wr_en;
  logic [1:0]    ch;
  logic          unused_bits;

  assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
  assign ch       = addr[3:2];
  assign wr_en    = mem_write && hit && byte_en[0];
  assign tick     = (pre_left == '0);
  assign boundary = tick && (cnt == 8'hFF);

  assign unused_bits = ^{addr[1:0], byte_en[3:1], write_data[31:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_left  <= PRE_LOAD;
      cnt       <= 8'd0;
      read_data <= 32'd0;
      pwm_q     <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= 8'd0;
        active[i] <= 8'd0;
      end
    end else begin
      pre_left <= tick ? PRE_LOAD : pre_left - PW'(1);
      if (tick) begin
        cnt <= cnt + 8'd1;
      end
      if (wr_en) begin
        shadow[ch] <= write_data[7:0];
      end
      // active samples shadow before any same-cycle write lands
      if (boundary) begin
        for (int i = 0; i < 4; i++) begin
          active[i] <= shadow[i];
        end
      end
      read_data <= hit ? {24'd0, shadow[ch]} : 32'd0;
      for (int i = 0; i < 4; i++) begin
        pwm_q[i] <= (cnt < active[i]);
      end
    end
  end

  assign led   = pwm_q[0];
  assign red   = pwm_q[1];
  assign green = pwm_q[2];
  assign blue  = pwm_q[3];

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl at PRESCALE=2 (512-cycle period); cyc counts
// edges since reset release, starting at 0 for the first edge with reset low.
module tb_led_pwm_ctrl;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  byte_en;
  logic [31:0] read_data;
  logic        led, red, green, blue;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int hi [4];

  led_pwm_ctrl #(.BASE_ADDR(BASE), .PRESCALE(2)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .byte_en(byte_en), .read_data(read_data),
    .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_hi();
    for (int i = 0; i < 4; i++) hi[i] = 0;
  endtask

  task automatic step();
    logic [3:0] o;
    @(posedge clk);
    #1;
    cyc++;
    o = {blue, green, red, led};
    for (int i = 0; i < 4; i++) hi[i] += (o[i] === 1'b1) ? 1 : 0;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    mem_write = 1'b0;
    repeat (n) step();
    reset = 1'b0;
    cyc = -1;
    clear_hi();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_write = 1'b1; addr = a; write_data = d; byte_en = be;
    step();
    mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_write = 1'b0; addr = BASE; write_data = '0; byte_en = 4'hF;
    cyc = 0;
    clear_hi();

    // reset state and two idle periods
    do_reset(3);
    chk("rst_outs", {28'd0, blue, green, red, led}, 32'd0);
    chk("rst_read", read_data, 32'd0);
    run_to(1023);
    chk("idle_hi_led", hi[0], 0);
    chk("idle_hi_red", hi[1], 0);
    chk("idle_hi_grn", hi[2], 0);
    chk("idle_hi_blu", hi[3], 0);

    // fresh timeline: programme duties, then check decode/lanes
    do_reset(2);
    wr(BASE + 32'h4, 32'h0000_0040, 4'hF);
    wr(BASE + 32'h0, 32'h0000_0000, 4'hF);
    wr(BASE + 32'hC, 32'h0000_00FF, 4'hF);
    wr(BASE + 32'h8, 32'h0000_0010, 4'hF);
    wr(32'h0000_0000, 32'h0000_00FF, 4'hF);
    wr(BASE + 32'h8, 32'h0000_FFFF, 4'b0010);
    addr = BASE + 32'h8;
    step();
    chk("rd_green_lanes", read_data, 32'h0000_0010);
    addr = 32'h0000_0000;
    step();
    chk("rd_nohit", read_data, 32'd0);

    // green write colliding with the first boundary (edge 511)
    run_to(510);
    mem_write = 1'b1; addr = BASE + 32'h8; write_data = 32'h0000_0080; byte_en = 4'hF;
    step();
    mem_write = 1'b0;
    chk("red_at_bnd", {31'd0, red}, 32'd0);
    chk("pre_bnd_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
    clear_hi();
    step();
    chk("red_bnd_p1", {31'd0, red}, 32'd1);
    run_to(639);
    chk("red_last_hi", {31'd0, red}, 32'd1);
    step();
    chk("red_first_lo", {31'd0, red}, 32'd0);
    run_to(1021);
    chk("blue_pre_lo", {31'd0, blue}, 32'd1);
    step();
    chk("blue_lo", {31'd0, blue}, 32'd0);
    run_to(1023);
    chk("blue_lo2", {31'd0, blue}, 32'd0);
    chk("p1_hi_led", hi[0], 0);
    chk("p1_hi_red", hi[1], 128);
    chk("p1_hi_grn", hi[2], 32);
    chk("p1_hi_blu", hi[3], 510);
    clear_hi();
    step();
    chk("blue_back_hi", {31'd0, blue}, 32'd1);
    run_to(1535);
    chk("p2_hi_led", hi[0], 0);
    chk("p2_hi_red", hi[1], 128);
    chk("p2_hi_grn", hi[2], 256);
    chk("p2_hi_blu", hi[3], 510);

    // lane-0 store with junk upper bytes; readback is pre-write then new
    wr(BASE + 32'hC, 32'hDEAD_BE33, 4'hF);
    chk("rd_blue_prewr", read_data, 32'h0000_00FF);
    step();
    chk("rd_blue_new", read_data, 32'h0000_0033);
    run_to(2047);
    clear_hi();
    run_to(2559);
    chk("p4_hi_blu", hi[3], 102);
    chk("p4_hi_red", hi[1], 128);

    // all duties 0x80, then reset halfway through a period
    wr(BASE + 32'h0, 32'h80, 4'hF);
    wr(BASE + 32'h4, 32'h80, 4'hF);
    wr(BASE + 32'h8, 32'h80, 4'hF);
    wr(BASE + 32'hC, 32'h80, 4'hF);
    run_to(3271);
    chk("mid_outs_hi", {28'd0, blue, green, red, led}, 32'h0000_000F);
    do_reset(1);
    chk("mid_rst_outs", {28'd0, blue, green, red, led}, 32'd0);
    chk("mid_rst_read", read_data, 32'd0);
    for (int c = 0; c < 4; c++) begin
      addr = BASE + 32'(c * 4);
      step();
      chk("rd_after_rst", read_data, 32'd0);
    end
    wr(BASE + 32'h4, 32'h0000_0001, 4'hF);
    run_to(511);
    chk("rst_red_bnd", {31'd0, red}, 32'd0);
    chk("rst_pre_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
    step();
    chk("rst_red_on", {31'd0, red}, 32'd1);
    step();
    chk("rst_red_on2", {31'd0, red}, 32'd1);
    step();
    chk("rst_red_off", {31'd0, red}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
